// File: rtl/z80_bus_tracer_if.sv
// Signal bundle between a Z80 bus tracer and its environment: CPU strobes,
// capture controls, trace read port and status.
interface z80_bus_tracer_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int OVF_W      = 8
) ();
  logic                  m1_n;
  logic                  mreq_n;
  logic                  iorq_n;
  logic                  rd_n;
  logic                  wr_n;
  logic                  rfsh_n;
  logic [15:0]           a;
  logic [7:0]            d;
  logic                  ena;
  logic                  mode_ring;
  logic                  trig_ena;
  logic [15:0]           trig_addr;
  logic                  rd_req;
  logic [26:0]           rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic [OVF_W-1:0]      ovf_cnt;
  logic [1:0]            state;

  // Read handshake: rd_req is a pop request, honoured only while empty==0.
  // rd_valid pulses for exactly one cycle after an honoured request, and
  // rd_data holds its value until the next honoured request.
  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, a, d,
    output ena, mode_ring, trig_ena, trig_addr, rd_req,
    input  rd_data, rd_valid, empty, full, count, ovf_cnt, state
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, a, d,
    input  ena, mode_ring, trig_ena, trig_addr, rd_req,
    output rd_data, rd_valid, empty, full, count, ovf_cnt, state
  );
endinterface

// File: rtl/z80_bus_tracer.sv
// Z80 bus-cycle tracer: records {type, addr, data} per completed bus cycle
// into a FIFO, with optional address trigger, ring mode and overflow count.
module z80_bus_tracer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int OVF_W      = 8
) (
  input  logic           fclk,
  input  logic           rst,
  z80_bus_tracer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_STOPPED = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  in_cyc_q, in_cyc_d;
  logic                  block_q, block_d;
  logic [15:0]           addr_q, addr_d;
  logic [2:0]            type_q, type_d;
  logic [7:0]            data_q, data_d;
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [OVF_W-1:0]      ovf_q;
  logic [26:0]           rd_data_q;
  logic                  rd_valid_q;
  logic [26:0]           mem_q [DEPTH];

  logic                  active;
  logic                  rec_gen;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_req;
  logic                  do_write;
  logic                  ring_ovw;
  logic                  stop_ovf;
  logic                  rptr_adv;
  logic                  ovf_clr;
  logic [26:0]           rec;

  assign active  = (~bus.mreq_n | ~bus.iorq_n) & (~bus.rd_n | ~bus.wr_n) & bus.rfsh_n;
  assign rec_gen = in_cyc_q & ~active & bus.ena;
  assign rec     = {type_q, addr_q, data_q};
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = bus.rd_req & ~empty;

  // block_q suppresses a cycle that was already running when it was aborted
  // (reset or ena low) until the bus goes idle again.
  always_comb begin
    in_cyc_d = in_cyc_q;
    block_d  = block_q;
    addr_d   = addr_q;
    type_d   = type_q;
    data_d   = data_q;
    if (!bus.ena) begin
      in_cyc_d = 1'b0;
      block_d  = 1'b1;
    end else if (active) begin
      if (!in_cyc_q && !block_q) begin
        in_cyc_d = 1'b1;
        addr_d   = bus.a;
        type_d   = {~bus.iorq_n, ~bus.wr_n, ~bus.m1_n};
        data_d   = bus.d;
      end else if (in_cyc_q) begin
        data_d = bus.d;
      end
    end else begin
      in_cyc_d = 1'b0;
      block_d  = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    ovf_clr  = 1'b0;
    if (!bus.ena) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = bus.trig_ena ? S_ARMED : S_CAPTURE;
          ovf_clr = 1'b1;
        end
        S_ARMED: begin
          if (rec_gen && (addr_q == bus.trig_addr)) begin
            push_req = 1'b1;
            state_d  = S_CAPTURE;
          end
        end
        S_CAPTURE: push_req = rec_gen;
        S_STOPPED: state_d = S_STOPPED;
        default:   state_d = S_IDLE;
      endcase
    end
    // A pop on the same edge frees a slot, so only an unpopped full buffer overflows.
    do_write = push_req & (~full | pop | bus.mode_ring);
    ring_ovw = push_req & full & ~pop & bus.mode_ring;
    stop_ovf = push_req & full & ~pop & ~bus.mode_ring;
    rptr_adv = pop | ring_ovw;
    if (stop_ovf) state_d = S_STOPPED;
    count_d = count_q;
    if (do_write && !rptr_adv)      count_d = count_q + 1'b1;
    else if (!do_write && rptr_adv) count_d = count_q - 1'b1;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_cyc_q   <= 1'b0;
      block_q    <= 1'b1;
      addr_q     <= '0;
      type_q     <= '0;
      data_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cyc_q   <= in_cyc_d;
      block_q    <= block_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      data_q     <= data_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (pop)      rd_data_q <= mem_q[rptr_q];
      if (do_write) wptr_q    <= wptr_q + 1'b1;
      if (rptr_adv) rptr_q    <= rptr_q + 1'b1;
      if (ovf_clr) begin
        ovf_q <= '0;
      end else if ((ring_ovw || stop_ovf) && (ovf_q != '1)) begin
        ovf_q <= ovf_q + 1'b1;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst && do_write) mem_q[wptr_q] <= rec;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.ovf_cnt  = ovf_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed bench for z80_bus_tracer: transaction-level queue model checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_z80_bus_tracer;
  localparam int DEPTH_LOG2 = 4;
  localparam int OVF_W      = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int OVF_MAX    = (1 << OVF_W) - 1;
  localparam logic [1:0] M_IDLE = 2'd0, M_ARMED = 2'd1, M_CAPTURE = 2'd2, M_STOPPED = 2'd3;

  logic fclk;
  logic rst;
  z80_bus_tracer_if #(.DEPTH_LOG2(DEPTH_LOG2), .OVF_W(OVF_W)) bus ();

  z80_bus_tracer #(.DEPTH_LOG2(DEPTH_LOG2), .OVF_W(OVF_W)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  // clock / reset
  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // model and scoreboard
  logic [26:0] m_q[$];
  logic [26:0] exp_q[$];
  logic [26:0] m_hold;
  logic        m_rdv;
  int          m_ovf;
  logic [1:0]  m_state;
  logic        pend;
  logic [26:0] pend_rec;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_ovf();
    if (m_ovf < OVF_MAX) m_ovf++;
  endtask

  task automatic model_record(input logic [26:0] r);
    logic [26:0] dropped;
    if (m_state == M_ARMED) begin
      if (r[23:8] != bus.trig_addr) return;
      m_state = M_CAPTURE;
    end
    if (m_state != M_CAPTURE) return;
    if (m_q.size() < DEPTH) begin
      m_q.push_back(r);
    end else if (bus.mode_ring) begin
      dropped = m_q.pop_front();
      m_q.push_back(r);
      model_ovf();
    end else begin
      model_ovf();
      m_state = M_STOPPED;
    end
  endtask

  task automatic compare_all();
    chk("count", 32'(bus.count), 32'(m_q.size()));
    chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
    chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    chk("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_ovf));
    chk("state", 32'(bus.state), 32'(m_state));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    if (m_rdv && exp_q.size() > 0) m_hold = exp_q.pop_front();
    chk("rd_data", 32'(bus.rd_data), 32'(m_hold));
  endtask

  // one clock: inputs held across the edge, model applies that edge, compare at negedge
  task automatic cyc(input bit pop);
    bus.rd_req = pop;
    @(posedge fclk);
    #1;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_hold  = '0;
      m_rdv   = 1'b0;
      m_ovf   = 0;
      m_state = M_IDLE;
    end else begin
      m_rdv = 1'b0;
      if (pop && m_q.size() > 0) begin
        exp_q.push_back(m_q.pop_front());
        m_rdv = 1'b1;
      end
      if (!bus.ena) begin
        m_state = M_IDLE;
      end else if (m_state == M_IDLE) begin
        m_state = bus.trig_ena ? M_ARMED : M_CAPTURE;
        m_ovf   = 0;
      end else if (pend) begin
        model_record(pend_rec);
      end
    end
    pend       = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge fclk);
    compare_all();
  endtask

  // driver tasks
  task automatic idle_bus();
    bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
    bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.rfsh_n = 1'b1;
  endtask

  task automatic bus_cyc(input logic [2:0] ty, input logic [15:0] ad, input logic [7:0] dt,
                         input bit pop_end);
    bus.a      = ad;
    bus.iorq_n = ~ty[2];
    bus.mreq_n = ty[2];
    bus.wr_n   = ~ty[1];
    bus.rd_n   = ty[1];
    bus.m1_n   = ~ty[0];
    bus.d      = ~dt;
    cyc(1'b0);
    cyc(1'b0);
    bus.d = dt;
    cyc(1'b0);
    idle_bus();
    pend     = 1'b1;
    pend_rec = {ty, ad, dt};
    cyc(pop_end);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
  endtask

  task automatic start(input bit trig, input bit ring, input logic [15:0] taddr);
    bus.ena = 1'b0;
    do_reset();
    bus.trig_ena  = trig;
    bus.mode_ring = ring;
    bus.trig_addr = taddr;
    bus.ena       = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    errors = 0; checks = 0;
    m_hold = '0; m_rdv = 1'b0; m_ovf = 0; m_state = M_IDLE;
    pend = 1'b0; pend_rec = '0;
    rst = 1'b1;
    idle_bus();
    bus.a = '0; bus.d = '0; bus.ena = 1'b0; bus.mode_ring = 1'b0;
    bus.trig_ena = 1'b0; bus.trig_addr = '0; bus.rd_req = 1'b0;
    do_reset();
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);

    // M1 fetch at 0x0000, d=0xF3
    start(1'b0, 1'b0, 16'h0000);
    bus_cyc(3'b001, 16'h0000, 8'hF3, 1'b0);
    chk("fetch_count", 32'(bus.count), 32'd1);
    cyc(1'b1);
    chk("fetch_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("fetch_rd_data", 32'(bus.rd_data), 32'h010000F3);
    chk("fetch_empty", 32'(bus.empty), 32'd1);
    cyc(1'b1);
    cyc(1'b0);

    // trigger on 0x15E0
    start(1'b1, 1'b0, 16'h15E0);
    chk("trig_armed", 32'(bus.state), 32'd1);
    bus_cyc(3'b000, 16'h15DF, 8'h11, 1'b0);
    bus_cyc(3'b000, 16'h15E0, 8'h22, 1'b0);
    bus_cyc(3'b000, 16'h15E1, 8'h33, 1'b0);
    chk("trig_count", 32'(bus.count), 32'd2);
    chk("trig_state", 32'(bus.state), 32'd2);
    cyc(1'b1);
    chk("trig_first_addr", 32'(bus.rd_data[23:8]), 32'h15E0);
    cyc(1'b1);

    // non-ring overflow: 17 writes then an 18th
    start(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 17; i++) bus_cyc(3'b010, 16'(i), 8'(i + 8'h40), 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_cnt", 32'(bus.ovf_cnt), 32'd1);
    chk("ovf_state", 32'(bus.state), 32'd3);
    bus_cyc(3'b010, 16'h0011, 8'h99, 1'b0);
    chk("ovf_18th_count", 32'(bus.count), 32'd16);
    cyc(1'b1);
    chk("stopped_read_addr", 32'(bus.rd_data[23:8]), 32'h0000);

    // ring overflow: 20 IO reads, then a push with a pop on the same edge
    start(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) bus_cyc(3'b100, 16'(i), 8'(i), 1'b0);
    chk("ring_count", 32'(bus.count), 32'd16);
    chk("ring_ovf", 32'(bus.ovf_cnt), 32'd4);
    bus_cyc(3'b100, 16'd20, 8'h14, 1'b1);
    chk("pushpop_count", 32'(bus.count), 32'd16);
    chk("pushpop_ovf", 32'(bus.ovf_cnt), 32'd4);
    chk("ring_first_addr", 32'(bus.rd_data[23:8]), 32'd4);
    chk("ring_first_type", 32'(bus.rd_data[26:24]), 32'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1);

    // reset in the middle of a cycle
    start(1'b0, 1'b0, 16'h0000);
    bus.a = 16'h1234; bus.d = 8'h56; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    chk("rst_abort_state", 32'(bus.state), 32'd0);
    cyc(1'b0);
    cyc(1'b0);
    idle_bus();
    cyc(1'b0);
    cyc(1'b0);
    chk("rst_abort_count", 32'(bus.count), 32'd0);

    // ena drop in the middle of a cycle
    bus.a = 16'h4321; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    bus.ena = 1'b0;
    cyc(1'b0);
    idle_bus();
    cyc(1'b0);
    chk("ena_abort_state", 32'(bus.state), 32'd0);
    chk("ena_abort_count", 32'(bus.count), 32'd0);

    // refresh cycles are never recorded
    bus.ena = 1'b1;
    cyc(1'b0);
    bus.a = 16'h007F; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.rfsh_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    idle_bus();
    cyc(1'b0);
    cyc(1'b0);
    chk("rfsh_count", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z80_bus_tracer.md
Z80_BUS_TRACER -- requirements
Module: z80_bus_tracer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, trace buffer depth = 2**DEPTH_LOG2 records.
REQ-002 SHALL have parameter OVF_W, default 8, width of the overflow counter.
REQ-003 SHALL have ports fclk in 1 (sole clock) and rst in 1 (synchronous reset, active-high); all logic clocked on posedge fclk.
REQ-004 SHALL have inputs m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, each 1 bit: Z80 strobes, already synchronized to fclk.
REQ-005 SHALL have inputs a in 16 (Z80 address) and d in 8 (Z80 data bus, driven by CPU or DUT).
REQ-006 SHALL have control inputs: ena in 1 (capture enable), mode_ring in 1 (1 = overwrite oldest when full), trig_ena in 1, trig_addr in 16.
REQ-007 SHALL have read side: rd_req in 1, rd_data out 27 ({type[2:0], addr[15:0], data[7:0]}), rd_valid out 1.
REQ-008 SHALL have status outputs: empty out 1, full out 1, count out DEPTH_LOG2+1, ovf_cnt out OVF_W, state out 2.

Function
REQ-009 SHALL treat a bus cycle as active when (mreq_n==0 or iorq_n==0) and (rd_n==0 or wr_n==0) and rfsh_n==1.
REQ-010 SHALL latch a and type on the first fclk of an active cycle; type = {io = ~iorq_n, wr = ~wr_n, m1 = ~m1_n}.
REQ-011 SHALL latch d on every fclk the cycle is active, so the last sampled value is recorded.
REQ-012 SHALL generate a record on the first fclk after the cycle goes inactive; the record is written into the buffer on that same edge.
REQ-013 SHALL implement FSM states IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3 on output state.
REQ-014 SHALL transition IDLE->ARMED when ena==1 and trig_ena==1, and IDLE->CAPTURE when ena==1 and trig_ena==0.
REQ-015 SHALL transition ARMED->CAPTURE when a cycle ends with latched addr==trig_addr; that cycle SHALL be stored as the first record. Non-matching cycles in ARMED SHALL NOT be stored.
REQ-016 SHALL, in any state, go to IDLE on the edge where ena==0; a cycle in progress at that time SHALL be discarded; buffer contents are kept.
REQ-017 SHALL, when a record is generated in CAPTURE with mode_ring==0 and full==1 and no simultaneous pop, discard the record, increment ovf_cnt and enter STOPPED.
REQ-018 SHALL, in STOPPED, store no records; the only exit is ena==0 -> IDLE.
REQ-019 SHALL, in CAPTURE with mode_ring==1 and full==1 and no simultaneous pop, overwrite the oldest record (read pointer advances), keep count unchanged, and increment ovf_cnt.
REQ-020 SHALL saturate ovf_cnt at 2**OVF_W-1; ovf_cnt SHALL clear only on reset or on IDLE->ARMED/CAPTURE transition.
REQ-021 SHALL pop the oldest record when rd_req==1 and empty==0; rd_data SHALL be valid with rd_valid==1 on the following cycle only; rd_req while empty SHALL be ignored (rd_valid=0, rd_data held).
REQ-022 SHALL, on simultaneous push and pop while full, perform both, with count unchanged, ovf_cnt unchanged and no transition to STOPPED.
REQ-023 SHALL, on simultaneous push and pop while empty, return the old rd_data hold behaviour (pop ignored) and store the record; count becomes 1.
REQ-024 SHALL maintain count in 0..2**DEPTH_LOG2, full = (count==2**DEPTH_LOG2), empty = (count==0); pointers SHALL wrap modulo depth.
REQ-025 SHALL allow reads in every state, including IDLE and STOPPED.

Reset
REQ-026 SHALL on rst==1 set state=IDLE, pointers=0, count=0, empty=1, full=0, ovf_cnt=0, rd_valid=0, rd_data=0, and clear the cycle-in-progress flag; rst SHALL override all other inputs.
REQ-027 SHALL, when rst is asserted mid-cycle, discard that cycle; the cycle SHALL NOT be recorded after rst deasserts even if still active.

Verification
REQ-028 SHALL cover fetch: ena=1, trig_ena=0, M1 fetch at 0x0000, d=0xF3 -> one record {3'b001,0x0000,0xF3}, count=1, rd_req -> rd_valid next cycle with that value, empty=1.
REQ-029 SHALL cover trigger: trig_addr=0x15E0, cycles at 0x15DF, 0x15E0, 0x15E1 -> exactly two records, first addr 0x15E0, state=CAPTURE.
REQ-030 SHALL cover non-ring overflow: DEPTH_LOG2=4, 17 mem writes, no reads -> count=16, ovf_cnt=1, state=STOPPED, 18th cycle not stored.
REQ-031 SHALL cover ring overflow: mode_ring=1, 20 IO reads at addr 0..19 -> count=16, ovf_cnt=4, first pop addr=4, type=3'b100.
REQ-032 SHALL cover full push+pop on the same edge -> count stays 16, ovf_cnt unchanged.
REQ-033 SHALL cover reset and ena abort: rst or ena=0 mid-cycle -> no record, state=IDLE; rfsh cycles are never recorded.
